adc_imi_multi: RTL and testbench

ADC_IMI_MULTI -- requirements
Module: adc_imi_multi

---
 rtl/adc_imi_multi.sv | 211 +++++++++++++++++++++
 tb/tb_adc_imi_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/adc_imi_multi.sv
//------------------------------------------------------------------------------
// adc_imi_multi : multi-channel ADC imitator with an SPI-like serial frame
//                 and a triangle/sawtooth/constant pattern generator per channel
// Revision      : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module adc_imi_multi #(
  parameter int DATA_W    = 16,
  parameter int CH_NUM    = 4,
  parameter int FRAME_LEN = 40,
  parameter int PEAK      = 4090,
  parameter int STEP      = 1,
  localparam int CH_W     = (CH_NUM > 1) ? $clog2(CH_NUM) : 1
) (
  input  logic              clk_100,
  input  logic              reset_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] const_val,
  input  logic              mdi,
  output logic              sck,
  output logic              cs_n,
  output logic              sdo,
  output logic              en,
  output logic [DATA_W-1:0] adc_data,
  output logic [CH_W-1:0]   ch_id,
  output logic [DATA_W-1:0] rx_data
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_SHIFT = 3'd2,
    S_DONE  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  localparam int                CNT_W      = $clog2(FRAME_LEN);
  localparam logic [CNT_W-1:0]  SHIFT_LAST = CNT_W'(2 * DATA_W);
  localparam logic [CNT_W-1:0]  FRAME_LAST = CNT_W'(FRAME_LEN - 1);
  localparam logic [DATA_W:0]   PEAK_X     = (DATA_W + 1)'(PEAK);
  localparam logic [DATA_W:0]   STEP_X     = (DATA_W + 1)'(STEP);
  localparam logic [CH_W-1:0]   CH_LAST    = CH_W'(CH_NUM - 1);

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [CH_W-1:0]     ptr_q;
  logic [1:0]          mode_q;
  logic [DATA_W-1:0]   tx_sh_q;
  logic [DATA_W-1:0]   rx_sh_q;
  logic [DATA_W-1:0]   sample_q;
  logic [DATA_W-1:0]   val_q [CH_NUM];
  logic [CH_NUM-1:0]   dir_q;

  logic                sck_q;
  logic                cs_n_q;
  logic                sdo_q;
  logic                en_q;
  logic [DATA_W-1:0]   adc_q;
  logic [CH_W-1:0]     ch_q;
  logic [DATA_W-1:0]   rx_q;

  logic [DATA_W-1:0]   sample_d;
  logic [DATA_W-1:0]   val_d;
  logic                dir_d;
  logic [DATA_W:0]     cur_d;
  logic [DATA_W:0]     inc_d;

  assign sample_d = mode[1] ? const_val : val_q[ptr_q];

  // Pattern step for the channel being sent; one extra bit keeps the
  // comparisons against PEAK free of wrap-around.
  always_comb begin
    cur_d = {1'b0, val_q[ptr_q]};
    inc_d = cur_d + STEP_X;
    val_d = val_q[ptr_q];
    dir_d = dir_q[ptr_q];
    case (mode_q)
      2'd0: begin
        if (dir_q[ptr_q]) begin
          if (inc_d >= PEAK_X) begin
            val_d = PEAK_X[DATA_W-1:0];
            dir_d = 1'b0;
          end else begin
            val_d = inc_d[DATA_W-1:0];
          end
        end else begin
          if (cur_d <= STEP_X) begin
            val_d = '0;
            dir_d = 1'b1;
          end else begin
            val_d = val_q[ptr_q] - STEP_X[DATA_W-1:0];
          end
        end
      end
      2'd1: begin
        val_d = (inc_d > PEAK_X) ? '0 : inc_d[DATA_W-1:0];
        dir_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_100 or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      mode_q   <= 2'd0;
      tx_sh_q  <= '0;
      rx_sh_q  <= '0;
      sample_q <= '0;
      for (int i = 0; i < CH_NUM; i++) val_q[i] <= '0;
      dir_q    <= '1;
      sck_q    <= 1'b0;
      cs_n_q   <= 1'b1;
      sdo_q    <= 1'b0;
      en_q     <= 1'b0;
      adc_q    <= '0;
      ch_q     <= '0;
      rx_q     <= '0;
    end else begin
      en_q <= 1'b0;
      // Dropping start aborts the frame at once; last results stay visible.
      if (state_q != S_IDLE && !start) begin
        state_q <= S_IDLE;
        cnt_q   <= '0;
        ptr_q   <= '0;
        for (int i = 0; i < CH_NUM; i++) val_q[i] <= '0;
        dir_q   <= '1;
        sck_q   <= 1'b0;
        cs_n_q  <= 1'b1;
        sdo_q   <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            cnt_q  <= '0;
            sck_q  <= 1'b0;
            cs_n_q <= 1'b1;
            sdo_q  <= 1'b0;
            if (start) state_q <= S_LOAD;
          end
          S_LOAD: begin
            mode_q   <= mode;
            sample_q <= sample_d;
            tx_sh_q  <= sample_d;
            cs_n_q   <= 1'b0;
            sck_q    <= 1'b0;
            sdo_q    <= 1'b0;
            cnt_q    <= cnt_q + 1'b1;
            state_q  <= S_SHIFT;
          end
          S_SHIFT: begin
            cs_n_q <= 1'b0;
            sdo_q  <= tx_sh_q[DATA_W-1];
            // Odd count is the low half of a bit, even count the high half.
            if (cnt_q[0]) begin
              sck_q <= 1'b0;
            end else begin
              sck_q   <= 1'b1;
              rx_sh_q <= {rx_sh_q[DATA_W-2:0], mdi};
              tx_sh_q <= tx_sh_q << 1;
            end
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == SHIFT_LAST) state_q <= S_DONE;
          end
          S_DONE: begin
            cs_n_q       <= 1'b1;
            sck_q        <= 1'b0;
            sdo_q        <= 1'b0;
            en_q         <= 1'b1;
            adc_q        <= sample_q;
            ch_q         <= ptr_q;
            rx_q         <= rx_sh_q;
            val_q[ptr_q] <= val_d;
            dir_q[ptr_q] <= dir_d;
            ptr_q        <= (ptr_q == CH_LAST) ? '0 : ptr_q + 1'b1;
            if (cnt_q == FRAME_LAST) begin
              cnt_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              state_q <= S_GAP;
            end
          end
          S_GAP: begin
            if (cnt_q == FRAME_LAST) begin
              cnt_q   <= '0;
              state_q <= S_LOAD;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign sck      = sck_q;
  assign cs_n     = cs_n_q;
  assign sdo      = sdo_q;
  assign en       = en_q;
  assign adc_data = adc_q;
  assign ch_id    = ch_q;
  assign rx_data  = rx_q;

endmodule

`default_nettype wire

// File: tb/tb_adc_imi_multi.sv
//------------------------------------------------------------------------------
// tb_adc_imi_multi : directed self-checking bench for adc_imi_multi
// Revision         : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_adc_imi_multi;

  logic clk_100 = 1'b0;
  always #5 clk_100 = ~clk_100;

  logic        reset_n;
  logic        start0, start1, start2;
  logic [1:0]  mode0;
  logic [15:0] const0;

  logic        sck0, cs_n0, sdo0, en0;
  logic [15:0] adc0, rx0;
  logic [1:0]  ch0;

  logic        sck1, cs_n1, sdo1, en1;
  logic [7:0]  adc1, rx1;
  logic [0:0]  ch1;

  logic        sck2, cs_n2, sdo2, en2;
  logic [15:0] adc2, rx2;
  logic [0:0]  ch2;

  logic unused_tb;
  assign unused_tb = ^{sck1, cs_n1, ch1, sck2, cs_n2, ch2, rx2};

  adc_imi_multi u_dut0 (
    .clk_100(clk_100), .reset_n(reset_n), .start(start0), .mode(mode0),
    .const_val(const0), .mdi(sdo0), .sck(sck0), .cs_n(cs_n0), .sdo(sdo0),
    .en(en0), .adc_data(adc0), .ch_id(ch0), .rx_data(rx0)
  );

  adc_imi_multi #(.DATA_W(8), .CH_NUM(1), .FRAME_LEN(20), .PEAK(10), .STEP(1)) u_dut1 (
    .clk_100(clk_100), .reset_n(reset_n), .start(start1), .mode(2'd0),
    .const_val(8'h00), .mdi(sdo1), .sck(sck1), .cs_n(cs_n1), .sdo(sdo1),
    .en(en1), .adc_data(adc1), .ch_id(ch1), .rx_data(rx1)
  );

  adc_imi_multi #(.DATA_W(16), .CH_NUM(1), .FRAME_LEN(34), .PEAK(20), .STEP(7)) u_dut2 (
    .clk_100(clk_100), .reset_n(reset_n), .start(start2), .mode(2'd1),
    .const_val(16'h0000), .mdi(sdo2), .sck(sck2), .cs_n(cs_n2), .sdo(sdo2),
    .en(en2), .adc_data(adc2), .ch_id(ch2), .rx_data(rx2)
  );

  int cyc = 0;
  always @(posedge clk_100) cyc <= cyc + 1;

  logic [31:0] q_adc0[$], q_ch0[$], q_rx0[$], q_t0[$];
  logic [31:0] q_adc1[$], q_rx1[$];
  logic [31:0] q_adc2[$], q_t2[$];
  int          rises0 = 0;
  int          rises_cs0 = 0;
  logic [15:0] bits0 = '0;
  logic        sck0_prev = 1'b0;

  always @(negedge clk_100) begin
    if (en0) begin
      q_adc0.push_back(32'(adc0));
      q_ch0.push_back(32'(ch0));
      q_rx0.push_back(32'(rx0));
      q_t0.push_back(32'(cyc));
    end
    if (sck0 && !sck0_prev) begin
      rises0 = rises0 + 1;
      if (!cs_n0) rises_cs0 = rises_cs0 + 1;
      bits0 = {bits0[14:0], sdo0};
    end
    sck0_prev = sck0;
    if (en1) begin
      q_adc1.push_back(32'(adc1));
      q_rx1.push_back(32'(rx1));
    end
    if (en2) begin
      q_adc2.push_back(32'(adc2));
      q_t2.push_back(32'(cyc));
    end
  end

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  function automatic int qsize(input int which);
    case (which)
      0:       return q_adc0.size();
      1:       return q_adc1.size();
      default: return q_adc2.size();
    endcase
  endfunction

  task automatic wait_pulses(input int which, input int n, input int budget);
    int k = 0;
    while (qsize(which) < n && k < budget) begin
      @(negedge clk_100); #1;
      k++;
    end
    chk($sformatf("pulses_dut%0d_reach_%0d", which, n), 32'(qsize(which) >= n), 32'd1);
  endtask

  logic [31:0] tri_exp [22] = '{0,1,2,3,4,5,6,7,8,9,10,9,8,7,6,5,4,3,2,1,0,1};
  logic [31:0] saw_exp [5]  = '{0,7,14,0,7};

  initial begin
    int base, base_cs, k, held;
    reset_n = 1'b1;
    start0 = 1'b1; start1 = 1'b1; start2 = 1'b1;
    mode0 = 2'd0; const0 = 16'h0000;
    #2 reset_n = 1'b0;

    // reset held low with start high
    repeat (3) @(negedge clk_100);
    #1;
    chk("rst_cs_n", 32'(cs_n0), 32'd1);
    chk("rst_sck", 32'(sck0), 32'd0);
    chk("rst_sdo", 32'(sdo0), 32'd0);
    chk("rst_en", 32'(en0), 32'd0);
    chk("rst_adc", 32'(adc0), 32'd0);
    chk("rst_ch", 32'(ch0), 32'd0);
    chk("rst_rx", 32'(rx0), 32'd0);
    chk("rst_sck_rises", 32'(rises0), 32'd0);
    reset_n = 1'b1;

    // round robin, triangle from zero on four channels
    wait_pulses(0, 5, 400);
    if (qsize(0) >= 5) begin
      for (int i = 0; i < 5; i++) begin
        chk($sformatf("rr_ch%0d", i), q_ch0[i], 32'(i % 4));
        chk($sformatf("rr_adc%0d", i), q_adc0[i], (i == 4) ? 32'd1 : 32'd0);
        chk($sformatf("rr_rx%0d", i), q_rx0[i], (i == 4) ? 32'd1 : 32'd0);
        if (i > 0) chk($sformatf("rr_gap%0d", i), q_t0[i] - q_t0[i-1], 32'd40);
      end
    end

    // constant mode serial format, takes effect on the next frame
    mode0   = 2'd2;
    const0  = 16'hA5C3;
    base    = rises0;
    base_cs = rises_cs0;
    wait_pulses(0, 6, 100);
    chk("ser_rises", 32'(rises0 - base), 32'd16);
    chk("ser_rises_cs_low", 32'(rises_cs0 - base_cs), 32'd16);
    chk("ser_bits", 32'(bits0), 32'h0000A5C3);
    chk("ser_adc", 32'(adc0), 32'h0000A5C3);
    chk("ser_rx", 32'(rx0), 32'h0000A5C3);
    chk("ser_ch", 32'(ch0), 32'd1);

    // abort during bit 5 of the next frame
    base = rises0;
    k = 0;
    while ((rises0 - base) < 5 && k < 60) begin
      @(negedge clk_100); #1;
      k++;
    end
    chk("abort_reached_bit5", 32'(rises0 - base), 32'd5);
    start0 = 1'b0;
    mode0  = 2'd0;
    @(negedge clk_100); #1;
    chk("abort_cs_n", 32'(cs_n0), 32'd1);
    chk("abort_sck", 32'(sck0), 32'd0);
    held = qsize(0);
    repeat (60) @(negedge clk_100);
    #1;
    chk("abort_no_en", 32'(qsize(0)), 32'd6);
    chk("idle_adc_held", 32'(adc0), 32'h0000A5C3);
    chk("idle_ch_held", 32'(ch0), 32'd1);
    start0 = 1'b1;
    wait_pulses(0, held + 1, 100);
    chk("restart_ch", 32'(ch0), 32'd0);
    chk("restart_adc", 32'(adc0), 32'd0);
    chk("restart_rx", 32'(rx0), 32'd0);

    // triangle turn-around at PEAK=10 and at zero, single channel
    wait_pulses(1, 22, 600);
    if (qsize(1) >= 22) begin
      for (int i = 0; i < 22; i++)
        chk($sformatf("tri_adc%0d", i), q_adc1[i], tri_exp[i]);
      chk("tri_rx10", q_rx1[10], 32'd10);
      chk("tri_rx19", q_rx1[19], 32'd1);
    end

    // sawtooth PEAK=20 STEP=7 with a gap-less 34-cycle frame
    wait_pulses(2, 5, 300);
    if (qsize(2) >= 5) begin
      for (int i = 0; i < 5; i++)
        chk($sformatf("saw_adc%0d", i), q_adc2[i], saw_exp[i]);
      chk("saw_period", q_t2[4] - q_t2[3], 32'd34);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
